// File: rtl/master_port.sv
// master_port: master-side serial bus port.
// Turns one read/write request from the local core into a request/grant
// handshake with the arbiter, shifts out an rw/address/data frame MSB first,
// then collects the slave response (ACK/NACK bit for writes, a data word for
// reads). If the grant is withdrawn while waiting for the response the port
// parks in SPLIT with the bus released and resumes when re-granted.
//
// Ports
//   clk, rstn                 clock, synchronous active-low reset
//   core_start/rw/addr/wdata  request from core (start sampled only when idle)
//   core_rdata                last successfully read word
//   core_busy                 transaction in progress
//   core_done, core_err       one-cycle completion pulse and its error flag
//   m_req, m_grant            arbiter request / grant bits
//   bus_util                  bus ownership (wired-OR outside)
//   bus_dout, bus_dvalid      serial frame out
//   bus_din, bus_din_valid    serial response in
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | no transaction, waiting for core_start
// WAIT_GNT  | m_req high, waiting for the arbiter grant
// TX        | owning the bus, shifting out the frame
// WAIT_RESP | owning the bus, collecting the response, timeout running
// SPLIT     | bus released by the arbiter, timeout frozen
// DONE      | single completion cycle reporting core_done/core_err

module master_port #(
   parameter int ADDR_W  = 12,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              core_start,
   input  logic              core_rw,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_busy,
   output logic              core_done,
   output logic              core_err,
   output logic              m_req,
   input  logic              m_grant,
   output logic              bus_util,
   output logic              bus_dout,
   output logic              bus_dvalid,
   input  logic              bus_din,
   input  logic              bus_din_valid
);

   localparam int FW   = 1 + ADDR_W + DATA_W;
   localparam int BC_W = $clog2(FW);
   localparam int RC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT - 1) : 1;

   localparam logic [BC_W-1:0] LAST_W  = BC_W'(FW - 1);
   localparam logic [BC_W-1:0] LAST_R  = BC_W'(ADDR_W);
   localparam logic [RC_W-1:0] RX_LAST = RC_W'(DATA_W - 1);
   localparam bit              TO_EN   = (TIMEOUT != 0);
   // Down-counter is loaded so that terminal count (0) lands on the
   // TIMEOUT-1'th idle cycle after a clear, i.e. DONE follows one cycle later.
   localparam logic [TO_W-1:0] TO_LOAD = TO_W'((TIMEOUT > 2) ? TIMEOUT - 2 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_WAIT_GNT, S_TX, S_WAIT_RESP, S_SPLIT, S_DONE
   } state_t;

   state_t state, state_nxt;

   logic            rw_q;
   logic [FW-1:0]   tx_sr;
   logic [BC_W-1:0] bit_cnt;
   logic [DATA_W-1:0] rx_sr;
   logic [RC_W-1:0] rx_cnt;
   logic [TO_W-1:0] to_cnt;

   logic err_nxt;
   logic rx_last;

   logic busy_d, done_d, err_d, req_d, util_d, dout_d, dvalid_d;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state      <= S_IDLE;
         rw_q       <= 1'b0;
         tx_sr      <= '0;
         bit_cnt    <= '0;
         rx_sr      <= '0;
         rx_cnt     <= '0;
         to_cnt     <= '0;
         core_rdata <= '0;
         core_busy  <= 1'b0;
         core_done  <= 1'b0;
         core_err   <= 1'b0;
         m_req      <= 1'b0;
         bus_util   <= 1'b0;
         bus_dout   <= 1'b0;
         bus_dvalid <= 1'b0;
      end else begin
         state      <= state_nxt;
         core_busy  <= busy_d;
         core_done  <= done_d;
         core_err   <= err_d;
         m_req      <= req_d;
         bus_util   <= util_d;
         bus_dout   <= dout_d;
         bus_dvalid <= dvalid_d;

         if (state == S_IDLE && core_start) begin
            rw_q  <= core_rw;
            tx_sr <= {core_rw, core_addr, core_rw ? core_wdata : {DATA_W{1'b0}}};
         end

         if (state_nxt == S_TX) begin
            tx_sr   <= tx_sr << 1;
            bit_cnt <= (state == S_TX) ? bit_cnt + BC_W'(1) : '0;
         end

         // Entry from TX or SPLIT discards any partial word and clears the timer.
         if (state_nxt == S_WAIT_RESP && state != S_WAIT_RESP) begin
            rx_cnt <= '0;
            to_cnt <= TO_LOAD;
         end else if (state == S_WAIT_RESP && state_nxt == S_WAIT_RESP) begin
            if (bus_din_valid) begin
               rx_sr  <= DATA_W'({rx_sr, bus_din});
               rx_cnt <= rx_cnt + RC_W'(1);
               to_cnt <= TO_LOAD;
            end else if (to_cnt != '0) begin
               to_cnt <= to_cnt - TO_W'(1);
            end
         end

         if (rx_last) core_rdata <= DATA_W'({rx_sr, bus_din});
      end
   end

   always_comb begin
      state_nxt = state;
      err_nxt   = 1'b0;
      rx_last   = 1'b0;
      unique case (state)
         S_IDLE:
            if (core_start) state_nxt = S_WAIT_GNT;
         S_WAIT_GNT:
            if (m_grant) state_nxt = S_TX;
         S_TX:
            if (!m_grant) begin
               state_nxt = S_DONE;
               err_nxt   = 1'b1;
            end else if (bit_cnt == (rw_q ? LAST_W : LAST_R)) begin
               state_nxt = S_WAIT_RESP;
            end
         S_WAIT_RESP:
            // A response bit only counts while we hold the grant.
            if (!m_grant) begin
               state_nxt = S_SPLIT;
            end else if (bus_din_valid) begin
               if (rw_q) begin
                  state_nxt = S_DONE;
                  err_nxt   = !bus_din;
               end else if (rx_cnt == RX_LAST) begin
                  state_nxt = S_DONE;
                  rx_last   = 1'b1;
               end
            end else if (TO_EN && to_cnt == '0) begin
               state_nxt = S_DONE;
               err_nxt   = 1'b1;
            end
         S_SPLIT:
            if (m_grant) state_nxt = S_WAIT_RESP;
         S_DONE:
            state_nxt = S_IDLE;
         default:
            state_nxt = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered.
   always_comb begin
      busy_d   = (state_nxt != S_IDLE);
      done_d   = (state_nxt == S_DONE);
      err_d    = err_nxt;
      req_d    = (state_nxt == S_WAIT_GNT);
      util_d   = (state_nxt == S_TX) || (state_nxt == S_WAIT_RESP);
      dvalid_d = (state_nxt == S_TX);
      dout_d   = (state_nxt == S_TX) ? tx_sr[FW-1] : 1'b0;
   end

endmodule

// File: tb/tb_master_port.sv
module tb_master_port;

   logic        clk = 1'b0;
   logic        rstn;
   logic        core_start, core_rw;
   logic [11:0] core_addr;
   logic [7:0]  core_wdata;
   logic [7:0]  core_rdata;
   logic        core_busy, core_done, core_err;
   logic        m_req, m_grant;
   logic        bus_util, bus_dout, bus_dvalid;
   logic        bus_din, bus_din_valid;

   int n_checks = 0;
   int n_err    = 0;
   logic [7:0] model_rdata;

   master_port #(.ADDR_W(12), .DATA_W(8), .TIMEOUT(16)) dut (
      .clk(clk), .rstn(rstn),
      .core_start(core_start), .core_rw(core_rw), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_rdata(core_rdata), .core_busy(core_busy),
      .core_done(core_done), .core_err(core_err),
      .m_req(m_req), .m_grant(m_grant),
      .bus_util(bus_util), .bus_dout(bus_dout), .bus_dvalid(bus_dvalid),
      .bus_din(bus_din), .bus_din_valid(bus_din_valid)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Frame as the spec defines it: rw, address, then data for writes only.
   function automatic logic [20:0] frame_of(input logic rw, input logic [11:0] a,
                                            input logic [7:0] d);
      if (rw) return (21'd1 << 20) | (21'(a) << 8) | 21'(d);
      return 21'(a);
   endfunction

   task automatic start_txn(input logic rw, input logic [11:0] a, input logic [7:0] d);
      core_rw = rw; core_addr = a; core_wdata = d; core_start = 1'b1;
      tick();
      core_start = 1'b0;
      chk1("m_req_rise", m_req, 1'b1);
      chk1("busy_rise", core_busy, 1'b1);
   endtask

   // Grants the bus now and collects the whole frame; returns one cycle after
   // the last frame bit with the grant still held.
   task automatic grant_frame(input logic rw, input logic [11:0] a, input logic [7:0] d);
      logic [20:0] got;
      int len, bad;
      len = rw ? 21 : 13;
      got = '0;
      bad = 0;
      m_grant = 1'b1;
      tick();
      for (int i = 0; i < len; i++) begin
         if (bus_dvalid !== 1'b1 || bus_util !== 1'b1 || m_req !== 1'b0) bad++;
         got = {got[19:0], bus_dout};
         tick();
      end
      chk("frame_bits", 32'(got), 32'(frame_of(rw, a, d)));
      chk("frame_ctrl_bad", 32'(bad), 32'd0);
      chk1("dvalid_after_frame", bus_dvalid, 1'b0);
      chk1("util_after_frame", bus_util, 1'b1);
   endtask

   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         bus_din_valid = 1'b1;
         bus_din = v[n-1-i];
         tick();
      end
      bus_din_valid = 1'b0;
      bus_din = 1'b0;
   endtask

   task automatic check_done(input string tag, input logic err_exp);
      chk1({tag, "_done"}, core_done, 1'b1);
      chk1({tag, "_err"}, core_err, err_exp);
      chk1({tag, "_util"}, bus_util, 1'b0);
      chk1({tag, "_dvalid"}, bus_dvalid, 1'b0);
      chk({tag, "_rdata"}, 32'(core_rdata), 32'(model_rdata));
      m_grant = 1'b0;
      tick();
      chk1({tag, "_done_clr"}, core_done, 1'b0);
      chk1({tag, "_idle"}, core_busy, 1'b0);
   endtask

   task automatic run_txn(input string tag, input logic rw, input logic [11:0] a,
                          input logic [7:0] d, input int gnt_gap, input int resp_gap,
                          input logic [7:0] resp);
      start_txn(rw, a, d);
      repeat (gnt_gap) tick();
      chk1({tag, "_util_pre_gnt"}, bus_util, 1'b0);
      grant_frame(rw, a, d);
      repeat (resp_gap - 1) tick();
      if (rw) begin
         send_bits(resp, 1);
         check_done(tag, ~resp[0]);
      end else begin
         send_bits(resp, 8);
         model_rdata = resp;
         check_done(tag, 1'b0);
      end
   endtask

   initial begin
      int done_at, bad;
      logic rw;
      logic [11:0] a;
      logic [7:0] d, r;

      rstn = 1'b0; core_start = 1'b0; core_rw = 1'b0; core_addr = '0;
      core_wdata = '0; m_grant = 1'b0; bus_din = 1'b0; bus_din_valid = 1'b0;
      model_rdata = 8'h00;
      tick(); tick();
      chk("reset_outs", 32'({core_busy, core_done, core_err, m_req, bus_util,
                             bus_dout, bus_dvalid}), 32'd0);
      chk("reset_rdata", 32'(core_rdata), 32'd0);
      rstn = 1'b1;
      tick();

      // Directed write with ACK, then read returning 0x3C.
      run_txn("wr_ack", 1'b1, 12'h123, 8'hA5, 3, 4, 8'h01);
      run_txn("rd_3c", 1'b0, 12'h0F0, 8'h00, 1, 2, 8'h3C);

      // Split read: one junk bit, grant withdrawn, 20-cycle park, re-grant.
      start_txn(1'b0, 12'h5A5, 8'h00);
      grant_frame(1'b0, 12'h5A5, 8'h00);
      send_bits(8'h01, 1);
      m_grant = 1'b0;
      tick();
      chk1("split_util", bus_util, 1'b0);
      chk1("split_req", m_req, 1'b0);
      bad = 0;
      repeat (20) begin
         tick();
         if (m_req !== 1'b0 || bus_util !== 1'b0 || core_done !== 1'b0) bad++;
      end
      chk("split_park_bad", 32'(bad), 32'd0);
      m_grant = 1'b1;
      tick();
      chk1("regrant_util", bus_util, 1'b1);
      send_bits(8'h81, 8);
      model_rdata = 8'h81;
      check_done("split", 1'b0);

      // Timeout with no response.
      start_txn(1'b0, 12'h777, 8'h00);
      grant_frame(1'b0, 12'h777, 8'h00);
      done_at = 0;
      for (int k = 1; k <= 24; k++) begin
         if (core_done === 1'b1) begin
            done_at = k;
            break;
         end
         tick();
      end
      chk("timeout_cycle", 32'(done_at), 32'd16);
      check_done("timeout", 1'b1);

      // Write NACK.
      run_txn("wr_nack", 1'b1, 12'hABC, 8'h3F, 0, 1, 8'h00);

      // Grant dropped mid-frame.
      start_txn(1'b1, 12'h321, 8'h55);
      m_grant = 1'b1;
      repeat (5) tick();
      chk1("abort_mid_dvalid", bus_dvalid, 1'b1);
      m_grant = 1'b0;
      tick();
      check_done("abort", 1'b1);

      // Reset held for one cycle mid-frame.
      start_txn(1'b1, 12'hFFF, 8'hFF);
      m_grant = 1'b1;
      repeat (4) tick();
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      m_grant = 1'b0;
      model_rdata = 8'h00;
      chk("midreset_outs", 32'({core_busy, core_done, core_err, m_req, bus_util,
                                bus_dout, bus_dvalid}), 32'd0);
      chk("midreset_rdata", 32'(core_rdata), 32'd0);
      tick();
      chk1("midreset_no_done", core_done, 1'b0);

      // Start while busy is ignored; the first request's frame goes out.
      start_txn(1'b0, 12'h246, 8'h00);
      core_rw = 1'b1; core_addr = 12'h9D1; core_wdata = 8'hEE; core_start = 1'b1;
      tick();
      core_start = 1'b0;
      chk1("busy_start_req", m_req, 1'b1);
      grant_frame(1'b0, 12'h246, 8'h00);
      send_bits(8'hC7, 8);
      model_rdata = 8'hC7;
      check_done("after_reset_rd", 1'b0);

      // Randomised transactions against the reference model.
      for (int t = 0; t < 8; t++) begin
         rw = 1'($urandom_range(0, 1));
         a  = 12'($urandom);
         d  = 8'($urandom);
         r  = 8'($urandom);
         run_txn($sformatf("rand%0d", t), rw, a, d, int'($urandom_range(0, 4)),
                 int'($urandom_range(1, 6)), r);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
